vga_object_scheduler: RTL and testbench



---
 rtl/vga_obj_pkg.sv | 45 ++++
 rtl/vga_obj_hit.sv | 32 +++
 rtl/vga_object_scheduler.sv | 127 ++++++++++++
 tb/tb_vga_object_scheduler.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_obj_pkg.sv
// Shared types, screen constants, palette and the horizontal
// move helper for the VGA object scheduler.
package vga_obj_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_UPDATE,
      S_COMMIT
   } state_t;

   localparam int H_ACTIVE = 640;
   localparam int V_ACTIVE = 480;

   // Entry 0 sits in the lowest 24 bits, so PALETTE[i] is object i.
   localparam logic [7:0][23:0] PALETTE = {
      24'h808080,
      24'hFF0000,
      24'h00FF00,
      24'h0000FF,
      24'h00FFFF,
      24'hFFFF00,
      24'hFF00FF,
      24'hFFFFFF
   };

   function automatic logic [9:0] move_x(
      input logic [9:0] x,
      input logic [2:0] spd,
      input logic       left
   );
      logic [10:0] s;
      if (!left) begin
         s = {1'b0, x} + {8'd0, spd};
         if (s >= 11'(H_ACTIVE))
            s = s - 11'(H_ACTIVE);
      end else begin
         if (x < {7'd0, spd})
            s = {1'b0, x} + 11'(H_ACTIVE) - {8'd0, spd};
         else
            s = {1'b0, x} - {8'd0, spd};
      end
      return s[9:0];
   endfunction

endpackage

// File: rtl/vga_obj_hit.sv
// Combinational hit test of one square against the current pixel.
// Columns past the visible area are never reported as hits.
module vga_obj_hit
   import vga_obj_pkg::*;
#(
   parameter int OBJ_W = 40,
   parameter int OBJ_H = 40,
   parameter int Y_TOP = 220
) (
   input  logic [9:0] x_pos,
   input  logic [9:0] pixel_x,
   input  logic [9:0] pixel_y,
   output logic       hit
);

   logic [10:0] x_end;
   logic        col_hit;
   logic        row_hit;

   assign x_end = {1'b0, x_pos} + 11'(OBJ_W);

   assign col_hit = (pixel_x >= x_pos)
                 && ({1'b0, pixel_x} < x_end)
                 && (pixel_x < 10'(H_ACTIVE));

   assign row_hit = (pixel_y >= 10'(Y_TOP))
                 && ({1'b0, pixel_y} < 11'(Y_TOP + OBJ_H))
                 && (pixel_y < 10'(V_ACTIVE));

   assign hit = col_hit && row_hit;

endmodule

// File: rtl/vga_object_scheduler.sv
// Frame-synchronous mover and renderer for a row of coloured squares.
// Define OBJ_BLINK_EN to hide odd objects while frame_count[5] is set.
module vga_object_scheduler
   import vga_obj_pkg::*;
#(
   parameter int NUM_OBJ   = 7,
   parameter int OBJ_W     = 40,
   parameter int OBJ_H     = 40,
   parameter int OBJ_PITCH = 50,
   parameter int INIT_X0   = 300,
   parameter int Y_TOP     = 220
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        enable,
   input  logic        frame_tick,
   input  logic [9:0]  pixel_X_pos,
   input  logic [9:0]  pixel_Y_pos,
   input  logic [2:0]  speed,
   input  logic        dir,
   input  logic        pause,
   output logic [7:0]  VGA_red,
   output logic [7:0]  VGA_green,
   output logic [7:0]  VGA_blue,
   output logic        busy,
   output logic [15:0] frame_count
);

   state_t      state;
   logic [2:0]  obj_idx;
   logic [2:0]  spd_q;
   logic        dir_q;
   logic [9:0]  work_x   [NUM_OBJ];
   logic [9:0]  commit_x [NUM_OBJ];
   logic [NUM_OBJ-1:0] vis;
   logic [23:0] color;
   logic [23:0] rgb_q;

   // Working positions change one per clock; rendering only ever
   // sees the committed copy, so a frame never shows a half move.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         frame_count <= '0;
         obj_idx     <= '0;
         spd_q       <= '0;
         dir_q       <= 1'b0;
         for (int i = 0; i < NUM_OBJ; i++) begin
            work_x[i]   <= 10'(INIT_X0 - i * OBJ_PITCH);
            commit_x[i] <= 10'(INIT_X0 - i * OBJ_PITCH);
         end
      end else begin
         case (state)
            S_IDLE: begin
               if (frame_tick && !pause) begin
                  state       <= S_UPDATE;
                  busy        <= 1'b1;
                  spd_q       <= speed;
                  dir_q       <= dir;
                  frame_count <= frame_count + 16'd1;
                  obj_idx     <= '0;
               end
            end
            S_UPDATE: begin
               work_x[obj_idx] <= move_x(work_x[obj_idx], spd_q, dir_q);
               if (obj_idx == 3'(NUM_OBJ - 1))
                  state <= S_COMMIT;
               else
                  obj_idx <= obj_idx + 3'd1;
            end
            S_COMMIT: begin
               for (int i = 0; i < NUM_OBJ; i++)
                  commit_x[i] <= work_x[i];
               state <= S_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   for (genvar i = 0; i < NUM_OBJ; i++) begin : g_obj
      logic hit;

      vga_obj_hit #(
         .OBJ_W (OBJ_W),
         .OBJ_H (OBJ_H),
         .Y_TOP (Y_TOP)
      ) u_hit (
         .x_pos   (commit_x[i]),
         .pixel_x (pixel_X_pos),
         .pixel_y (pixel_Y_pos),
         .hit     (hit)
      );

`ifdef OBJ_BLINK_EN
      localparam logic ODD = logic'(i % 2);
      assign vis[i] = hit & ~(ODD & frame_count[5]);
`else
      assign vis[i] = hit;
`endif
   end

   // Walk from the top index down so the lowest visible index wins.
   always_comb begin
      color = '0;
      for (int i = NUM_OBJ - 1; i >= 0; i--)
         if (vis[i])
            color = PALETTE[i[2:0]];
   end

   always_ff @(posedge clock) begin
      if (reset)
         rgb_q <= '0;
      else if (enable)
         rgb_q <= color;
   end

   assign VGA_red   = rgb_q[23:16];
   assign VGA_green = rgb_q[15:8];
   assign VGA_blue  = rgb_q[7:0];

endmodule

// File: tb/tb_vga_object_scheduler.sv
// Directed bench for vga_object_scheduler: pixel table after reset,
// then movement, wrap, ignore, overlap, mid-update reset and blink.
module tb_vga_object_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b1;
   logic       frame_tick = 1'b0;
   logic       pause = 1'b0;
   logic       dir = 1'b0;
   logic [2:0] speed = 3'd0;
   logic [9:0] px = '0;
   logic [9:0] py = '0;

   logic [7:0]  r, g, b;
   logic [7:0]  r2, g2, b2;
   logic        busy, busy2;
   logic [15:0] fc, fc2;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [9:0]  x;
      logic [9:0]  y;
      logic [23:0] rgb;
   } vec_t;

   vec_t vecs[16];

   always #10 clock = ~clock;

   vga_object_scheduler u_dut (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .frame_tick  (frame_tick),
      .pixel_X_pos (px),
      .pixel_Y_pos (py),
      .speed       (speed),
      .dir         (dir),
      .pause       (pause),
      .VGA_red     (r),
      .VGA_green   (g),
      .VGA_blue    (b),
      .busy        (busy),
      .frame_count (fc)
   );

   // Tighter pitch so objects 0 and 1 overlap by 20 columns.
   vga_object_scheduler #(.OBJ_PITCH(20)) u_ovl (
      .clock       (clock),
      .reset       (reset),
      .enable      (enable),
      .frame_tick  (frame_tick),
      .pixel_X_pos (px),
      .pixel_Y_pos (py),
      .speed       (speed),
      .dir         (dir),
      .pause       (pause),
      .VGA_red     (r2),
      .VGA_green   (g2),
      .VGA_blue    (b2),
      .busy        (busy2),
      .frame_count (fc2)
   );

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic pix(input logic [9:0] x, input logic [9:0] y,
                      input logic [23:0] exp, input string name);
      @(negedge clock);
      px = x;
      py = y;
      @(posedge clock);
      @(negedge clock);
      chk(name, {8'd0, r, g, b}, {8'd0, exp});
   endtask

   task automatic pix2(input logic [9:0] x, input logic [9:0] y,
                       input logic [23:0] exp, input string name);
      @(negedge clock);
      px = x;
      py = y;
      @(posedge clock);
      @(negedge clock);
      chk(name, {8'd0, r2, g2, b2}, {8'd0, exp});
   endtask

   task automatic tick(output int bcnt);
      @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      bcnt = 0;
      for (int k = 0; k < 40; k++) begin
         if (!busy) break;
         bcnt++;
         @(negedge clock);
      end
      if (busy) chk("tick_timeout", {31'd0, busy}, 32'd0);
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
   endtask

   int n;

   initial begin
      vecs[0]  = '{10'd300, 10'd220, 24'hFFFFFF};
      vecs[1]  = '{10'd0,   10'd0,   24'h000000};
      vecs[2]  = '{10'd339, 10'd259, 24'hFFFFFF};
      vecs[3]  = '{10'd340, 10'd220, 24'h000000};
      vecs[4]  = '{10'd299, 10'd220, 24'h000000};
      vecs[5]  = '{10'd250, 10'd230, 24'hFF00FF};
      vecs[6]  = '{10'd289, 10'd230, 24'hFF00FF};
      vecs[7]  = '{10'd200, 10'd240, 24'hFFFF00};
      vecs[8]  = '{10'd150, 10'd240, 24'h00FFFF};
      vecs[9]  = '{10'd100, 10'd240, 24'h0000FF};
      vecs[10] = '{10'd50,  10'd240, 24'h00FF00};
      vecs[11] = '{10'd0,   10'd240, 24'hFF0000};
      vecs[12] = '{10'd300, 10'd219, 24'h000000};
      vecs[13] = '{10'd300, 10'd260, 24'h000000};
      vecs[14] = '{10'd290, 10'd230, 24'h000000};
      vecs[15] = '{10'd39,  10'd259, 24'hFF0000};

      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("rst_rgb", {8'd0, r, g, b}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_fc", {16'd0, fc}, 32'd0);

      for (int i = 0; i < 16; i++)
         pix(vecs[i].x, vecs[i].y, vecs[i].rgb, $sformatf("tbl%0d", i));

      // RGB holds while the pixel strobe is low.
      @(negedge clock);
      enable = 1'b0;
      px = 10'd0;
      py = 10'd0;
      @(posedge clock);
      @(negedge clock);
      chk("hold", {8'd0, r, g, b}, 32'h00FF0000);
      enable = 1'b1;

      speed = 3'd2;
      dir = 1'b0;
      tick(n);
      chk("busy_len", n, 8);
      chk("fc_1", {16'd0, fc}, 32'd1);
      pix(10'd301, 10'd230, 24'h000000, "mv_301");
      pix(10'd341, 10'd230, 24'hFFFFFF, "mv_341");

      // 48 ticks at 7 from reset puts object 0 at 636.
      do_reset();
      speed = 3'd7;
      for (int i = 0; i < 48; i++) tick(n);
      pix(10'd636, 10'd230, 24'hFFFFFF, "at636");
      pix(10'd635, 10'd230, 24'h000000, "left636");
      tick(n);
      pix(10'd3,   10'd230, 24'hFFFFFF, "wrap_r3");
      pix(10'd2,   10'd230, 24'h000000, "wrap_r2");
      pix(10'd632, 10'd230, 24'hFF00FF, "wrap_o1");
      dir = 1'b1;
      tick(n);
      pix(10'd636, 10'd230, 24'hFFFFFF, "wrap_l636");
      pix(10'd3,   10'd230, 24'h000000, "wrap_l3");
      chk("fc_50", {16'd0, fc}, 32'd50);

      pause = 1'b1;
      tick(n);
      repeat (10) @(negedge clock);
      chk("pause_busy", n, 0);
      chk("pause_fc", {16'd0, fc}, 32'd50);
      pix(10'd636, 10'd230, 24'hFFFFFF, "pause_pos");
      pause = 1'b0;

      // Second tick lands while busy and must be dropped.
      speed = 3'd0;
      @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      repeat (2) @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      repeat (12) @(negedge clock);
      chk("busy_ign_fc", {16'd0, fc}, 32'd51);
      chk("busy_ign_b", {31'd0, busy}, 32'd0);
      pix(10'd636, 10'd230, 24'hFFFFFF, "busy_ign_pos");

      do_reset();
      pix2(10'd310, 10'd230, 24'hFFFFFF, "ovl_rst");
      speed = 3'd2;
      dir = 1'b0;
      for (int i = 0; i < 25; i++) tick(n);
      pix2(10'd355, 10'd230, 24'hFFFFFF, "ovl_355");
      pix2(10'd369, 10'd230, 24'hFFFFFF, "ovl_369");
      pix2(10'd349, 10'd230, 24'hFF00FF, "ovl_349");
      pix2(10'd375, 10'd230, 24'hFFFFFF, "ovl_375");

      // Reset lands in the third update clock.
      do_reset();
      speed = 3'd5;
      tick(n);
      pix(10'd344, 10'd230, 24'hFFFFFF, "pre_344");
      @(negedge clock);
      frame_tick = 1'b1;
      @(negedge clock);
      frame_tick = 1'b0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("mid_busy", {31'd0, busy}, 32'd0);
      chk("mid_fc", {16'd0, fc}, 32'd0);
      pix(10'd340, 10'd230, 24'h000000, "mid_340");
      speed = 3'd0;
      tick(n);
      pix(10'd300, 10'd230, 24'hFFFFFF, "mid_w300");
      pix(10'd290, 10'd230, 24'h000000, "mid_w290");

      do_reset();
      speed = 3'd0;
      for (int i = 0; i < 32; i++) tick(n);
      chk("fc_32", {16'd0, fc}, 32'd32);
      pix(10'd300, 10'd230, 24'hFFFFFF, "blk_o0");
`ifdef OBJ_BLINK_EN
      pix(10'd250, 10'd230, 24'h000000, "blk_o1");
`else
      pix(10'd250, 10'd230, 24'hFF00FF, "blk_o1");
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: run did not complete");
      $fatal(1);
   end

endmodule
